tof_i2c_sequencer: RTL and testbench

Transaction sequencer that sits directly upstream of the ToF I2C master. It accepts one register-level command at a time from the ToF control logic over a valid/ready handshake, drives the master's request inputs (slave address, 16-bit register address, direction, byte count, write data, start pulse), and tracks completion via the master's `ready` pulses. It returns read data and status over a second valid/ready handshake, with a watchdog so a stalled bus never hangs the controller.

---
 rtl/tof_i2c_sequencer.sv | 163 ++++++++++++++++
 tb/tb_tof_i2c_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tof_i2c_sequencer.sv
// tof_i2c_sequencer: issues one register-level command at a time to the ToF I2C master and returns the result.
// Latency: start one cycle after accept, response one cycle after completion; blocks new commands until the response is taken.
module tof_i2c_sequencer #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h29,
  parameter int         TIMEOUT_CYCLES = 200000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_is_read,
  input  logic        cmd_two_bytes,
  input  logic [15:0] cmd_reg_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        i2c_start,
  output logic [6:0]  i2c_slave_adress,
  output logic [15:0] i2c_register_address,
  output logic        i2c_is_read,
  output logic [16:0] i2c_nb_of_bytes,
  output logic [7:0]  i2c_data_in,
  input  logic        i2c_ready,
  input  logic [15:0] i2c_data_out,
  input  logic        i2c_error
);

  localparam int            CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESPOND
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wd_cnt;
  logic          ready_prev;
  logic          ready_edges;
  logic          sticky_error;
  logic          ready_rise;
  logic          done;
  logic          expire;
  logic          accept;

  assign i2c_slave_adress = SLAVE_ADDR;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Writes see an ack pulse for the data byte before the end-of-transfer pulse.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    ready_rise = i2c_ready & ~ready_prev;
    done       = 1'b0;
    expire     = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = cmd_valid & cmd_ready;
        if (accept) next_state = ST_LAUNCH;
      end
      ST_LAUNCH: next_state = ST_WAIT;
      ST_WAIT: begin
        done   = ready_rise & (i2c_is_read | ready_edges);
        expire = (wd_cnt == WD_LAST);
        if (done || expire) next_state = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (rsp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_prev <= 1'b0;
      cmd_ready  <= 1'b0;
      i2c_start  <= 1'b0;
    end else begin
      ready_prev <= i2c_ready;
      cmd_ready  <= (next_state == ST_IDLE);
      i2c_start  <= (next_state == ST_LAUNCH);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i2c_register_address <= '0;
      i2c_is_read          <= 1'b0;
      i2c_nb_of_bytes      <= '0;
      i2c_data_in          <= '0;
    end else if (accept) begin
      i2c_register_address <= cmd_reg_addr;
      i2c_is_read          <= cmd_is_read;
      i2c_data_in          <= cmd_wdata;
      if (!cmd_is_read) begin
        i2c_nb_of_bytes <= 17'd0;
      end else if (cmd_two_bytes) begin
        i2c_nb_of_bytes <= 17'd2;
      end else begin
        i2c_nb_of_bytes <= 17'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt       <= '0;
      ready_edges  <= 1'b0;
      sticky_error <= 1'b0;
    end else if (state == ST_LAUNCH) begin
      wd_cnt       <= '0;
      ready_edges  <= 1'b0;
      sticky_error <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
      if (ready_rise) ready_edges <= 1'b1;
      if (i2c_error) sticky_error <= 1'b1;
    end
  end

  // Completion takes priority over a watchdog expiry in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (done) begin
      rsp_valid   <= 1'b1;
      rsp_error   <= sticky_error | i2c_error;
      rsp_timeout <= 1'b0;
      if (!i2c_is_read) begin
        rsp_rdata <= 16'h0000;
      end else if (i2c_nb_of_bytes == 17'd2) begin
        rsp_rdata <= i2c_data_out;
      end else begin
        rsp_rdata <= {8'h00, i2c_data_out[7:0]};
      end
    end else if (expire) begin
      rsp_valid   <= 1'b1;
      rsp_rdata   <= 16'h0000;
      rsp_error   <= 1'b1;
      rsp_timeout <= 1'b1;
    end else if (state == ST_RESPOND && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tof_i2c_sequencer.sv
// Directed bench for tof_i2c_sequencer with a hand-driven I2C master model and a 16-cycle watchdog.
module tb_tof_i2c_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_is_read = 1'b0;
  logic        cmd_two_bytes = 1'b0;
  logic [15:0] cmd_reg_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        i2c_start;
  logic [6:0]  i2c_slave_adress;
  logic [15:0] i2c_register_address;
  logic        i2c_is_read;
  logic [16:0] i2c_nb_of_bytes;
  logic [7:0]  i2c_data_in;
  logic        i2c_ready = 1'b0;
  logic [15:0] i2c_data_out = '0;
  logic        i2c_error = 1'b0;

  int checks = 0;
  int passes = 0;
  int starts = 0;
  int s0;

  tof_i2c_sequencer #(.SLAVE_ADDR(7'h29), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_read(cmd_is_read),
    .cmd_two_bytes(cmd_two_bytes), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .i2c_start(i2c_start), .i2c_slave_adress(i2c_slave_adress),
    .i2c_register_address(i2c_register_address), .i2c_is_read(i2c_is_read),
    .i2c_nb_of_bytes(i2c_nb_of_bytes), .i2c_data_in(i2c_data_in),
    .i2c_ready(i2c_ready), .i2c_data_out(i2c_data_out), .i2c_error(i2c_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (i2c_start === 1'b1) starts <= starts + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents a command for one cycle; returns in the LAUNCH cycle.
  task automatic send(input logic rd, input logic two, input logic [15:0] ra, input logic [7:0] wd);
    cmd_is_read   = rd;
    cmd_two_bytes = two;
    cmd_reg_addr  = ra;
    cmd_wdata     = wd;
    cmd_valid     = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic take_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_done"}, {30'd0, cmd_ready, rsp_valid}, 32'h2);
  endtask

  initial begin
    #2 reset = 1'b0;
    #10;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_outs", {rsp_valid, rsp_error, rsp_timeout, i2c_start, i2c_is_read}, 0);
    chk("rst_fields", {rsp_rdata, i2c_register_address}, 0);
    chk("rst_fields2", {i2c_nb_of_bytes, i2c_data_in}, 0);
    chk("rst_slave", i2c_slave_adress, 32'h29);
    @(posedge clock);
    #1 reset = 1'b1;
    tick();
    chk("post_rst_ready", cmd_ready, 1);

    // write 0x0087 <= 0x01, two ready edges
    s0 = starts;
    send(1'b0, 1'b0, 16'h0087, 8'h01);
    chk("wr_start", {31'd0, i2c_start}, 1);
    chk("wr_fields", {i2c_register_address, i2c_data_in, 7'd0, i2c_is_read}, 32'h0087_0100);
    chk("wr_nb", i2c_nb_of_bytes, 0);
    chk("wr_cmd_ready_low", cmd_ready, 0);
    tick();
    chk("wr_start_gone", i2c_start, 0);
    i2c_ready = 1'b1;
    tick();
    i2c_ready = 1'b0;
    chk("wr_after_edge1", rsp_valid, 0);
    tick();
    i2c_ready = 1'b1;
    tick();
    i2c_ready = 1'b0;
    chk("wr_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, 32'h4_0000);
    chk("wr_one_start", starts - s0, 1);
    take_rsp("wr");

    // 16-bit read 0x010F -> 0xEACC
    send(1'b1, 1'b1, 16'h010F, 8'h00);
    chk("rd16_nb", i2c_nb_of_bytes, 2);
    chk("rd16_addr", {i2c_register_address, 15'd0, i2c_is_read}, 32'h010F_0001);
    tick();
    i2c_data_out = 16'hEACC;
    i2c_ready = 1'b1;
    tick();
    i2c_ready = 1'b0;
    chk("rd16_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, 32'h4_EACC);
    take_rsp("rd16");

    // 8-bit read -> upper byte masked
    send(1'b1, 1'b0, 16'h0030, 8'h00);
    chk("rd8_nb", i2c_nb_of_bytes, 1);
    tick();
    tick();
    i2c_data_out = 16'h12A0;
    i2c_ready = 1'b1;
    tick();
    i2c_ready = 1'b0;
    chk("rd8_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, 32'h4_00A0);
    take_rsp("rd8");

    // watchdog: no ready edge for 16 WAIT cycles
    send(1'b1, 1'b1, 16'h0001, 8'h00);
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("to_not_yet", rsp_valid, 0);
    tick();
    chk("to_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, 32'h7_0000);
    take_rsp("to");

    // ready edge on the final watchdog cycle: completion wins
    send(1'b1, 1'b1, 16'h0002, 8'h00);
    tick();
    for (int i = 0; i < 15; i++) tick();
    i2c_data_out = 16'h5A5A;
    i2c_ready = 1'b1;
    tick();
    i2c_ready = 1'b0;
    chk("race_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, 32'h4_5A5A);
    take_rsp("race");

    // single-cycle error mid-WAIT, then consumer stalls 10 cycles
    send(1'b1, 1'b1, 16'h0003, 8'h00);
    tick();
    tick();
    i2c_error = 1'b1;
    tick();
    i2c_error = 1'b0;
    tick();
    i2c_data_out = 16'h1234;
    i2c_ready = 1'b1;
    tick();
    i2c_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("err_hold", {rsp_valid, cmd_ready, rsp_error, rsp_timeout, rsp_rdata}, 32'h0A_1234);
      tick();
    end
    take_rsp("err");

    // asynchronous reset in WAIT
    send(1'b1, 1'b0, 16'h0004, 8'h00);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("arst_outs", {cmd_ready, rsp_valid, rsp_error, rsp_timeout, i2c_start, i2c_is_read}, 0);
    chk("arst_fields", {i2c_register_address, i2c_data_in}, 0);
    chk("arst_nb", {i2c_nb_of_bytes, rsp_rdata[14:0]}, 0);
    #2 reset = 1'b1;
    s0 = starts;
    tick();
    chk("arst_cmd_ready", cmd_ready, 1);
    tick();
    chk("arst_no_start", starts - s0, 0);
    send(1'b1, 1'b0, 16'h0005, 8'h00);
    tick();
    i2c_data_out = 16'hFF3C;
    i2c_ready = 1'b1;
    tick();
    i2c_ready = 1'b0;
    chk("arst_rd_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, 32'h4_003C);
    chk("arst_one_start", starts - s0, 1);
    take_rsp("arst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench time limit reached");
    $fatal(1, "bench time limit");
  end

endmodule
